// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind mem_read/mem_write strobes,
// with configurable wait states, a one-cycle ready pulse and an error qualifier. Rev 1.0
`default_nettype none

module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       accept, commit;

  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_rd, lat_wr;
  logic                  err_q;

  logic [ADDR_WIDTH+1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic                  op_rd, op_wr;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic                  op_bad, op_misaligned, do_store, do_load;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Upper address bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_read | mem_write) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = S_RESP;
            commit     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the live inputs are used.
  always_comb begin
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_rd    = lat_rd;
    op_wr    = lat_wr;
    if (state == S_IDLE) begin
      op_addr  = addr[ADDR_WIDTH+1:0];
      op_wdata = write_data;
      op_rd    = mem_read;
      op_wr    = mem_write;
    end
  end

  assign op_idx        = op_addr[ADDR_WIDTH+1:2];
  assign op_misaligned = |op_addr[1:0];
  assign op_bad        = (op_rd & op_wr) | op_misaligned;
  assign do_store      = commit & ~reset & op_wr & ~op_rd & ~op_misaligned;
  assign do_load       = commit & op_rd & ~op_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      read_data <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr  <= addr[ADDR_WIDTH+1:0];
        lat_wdata <= write_data;
        lat_rd    <= mem_read;
        lat_wr    <= mem_write;
      end
      if (commit) begin
        err_q <= op_bad;
      end
      if (do_load) begin
        read_data <= op_misaligned ? '0 : mem[op_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[op_idx] <= op_wdata;
    end
  end

  assign ready = (state == S_RESP);
  assign busy  = (state != S_IDLE);
  assign err   = ready & err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: WAIT_STATES=2 instance (u_a) and WAIT_STATES=0 instance (u_b).
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd_a, wr_a, ready_a, busy_a, err_a;
  logic [31:0] addr_a, wd_a, rdata_a;
  logic        rd_b, wr_b, ready_b, busy_b, err_b;
  logic [31:0] addr_b, wd_b, rdata_b;

  int n_vec = 0;
  int n_bad = 0;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) u_a (
    .clk(clk), .reset(reset), .mem_read(rd_a), .mem_write(wr_a), .addr(addr_a),
    .write_data(wd_a), .read_data(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .mem_read(rd_b), .mem_write(wr_b), .addr(addr_b),
    .write_data(wd_b), .read_data(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered just before the acceptance edge with strobes already driven.
  task automatic wait_resp_a(input string tag, input logic exp_err,
                             input logic chk_rd, input logic [31:0] exp_rd);
    int n;
    @(negedge clk);
    rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'hFFFF_FFFC; wd_a = 32'h0BAD_0BAD;
    check_vec({tag, " busy"}, 32'(busy_a), 32'd1);
    n = 1;
    while (!ready_a && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_vec({tag, " latency"}, 32'(n), 32'd3);
    check_vec({tag, " err"}, 32'(err_a), 32'(exp_err));
    if (chk_rd) check_vec({tag, " rdata"}, rdata_a, exp_rd);
    @(negedge clk);
    check_vec({tag, " idle"}, {30'b0, ready_a, busy_a}, 32'd0);
  endtask

  task automatic access_a(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rd);
    @(negedge clk);
    rd_a = rd; wr_a = wr; addr_a = a; wd_a = d;
    wait_resp_a(tag, exp_err, chk_rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wd_a = '0;
    rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wd_b = '0;
    @(negedge clk);
    @(negedge clk);
    check_vec("reset a outs", {29'b0, ready_a, busy_a, err_a}, 32'd0);
    check_vec("reset a rdata", rdata_a, 32'd0);
    check_vec("reset b outs", {29'b0, ready_b, busy_b, err_b}, 32'd0);
    check_vec("reset b rdata", rdata_b, 32'd0);
    reset = 1'b0;

    // Basic store/load with two wait states
    access_a("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    access_a("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Misaligned accesses
    access_a("st04", 1'b0, 1'b1, 32'h04, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    access_a("mis st06", 1'b0, 1'b1, 32'h06, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    access_a("ld04", 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    access_a("mis ld05", 1'b1, 1'b0, 32'h05, 32'h0, 1'b1, 1'b1, 32'h0);

    // Both strobes: no access, read_data held
    access_a("st20", 1'b0, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    access_a("ld10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    access_a("both 20", 1'b1, 1'b1, 32'h20, 32'h9999_9999, 1'b1, 1'b1, 32'hDEAD_BEEF);
    access_a("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h2222_2222);

    // Aliasing; the task also scrambles addr/data during WAIT
    access_a("st400", 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);
    access_a("ld000", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5);

    // Zero wait states, back-to-back store then load
    @(negedge clk);
    wr_b = 1'b1; addr_b = 32'h04; wd_b = 32'h1234_5678;
    @(negedge clk);
    check_vec("b st ready/err", {30'b0, ready_b, err_b}, 32'd2);
    wr_b = 1'b0; rd_b = 1'b1; wd_b = 32'h0;
    @(negedge clk);
    check_vec("b gap ready", 32'(ready_b), 32'd0);
    @(negedge clk);
    check_vec("b ld ready/err", {30'b0, ready_b, err_b}, 32'd2);
    check_vec("b ld rdata", rdata_b, 32'h1234_5678);
    rd_b = 1'b0;
    @(negedge clk);
    check_vec("b idle", {30'b0, ready_b, busy_b}, 32'd0);

    // Reset in the first WAIT cycle of a store
    access_a("st08", 1'b0, 1'b1, 32'h08, 32'h33, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    wr_a = 1'b1; addr_a = 32'h08; wd_a = 32'h55;
    @(negedge clk);
    check_vec("rst pre busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    check_vec("rst outs", {29'b0, ready_a, busy_a, err_a}, 32'd0);
    check_vec("rst rdata", rdata_a, 32'd0);
    @(negedge clk);
    wr_a = 1'b0; rd_a = 1'b1; addr_a = 32'h08;
    reset = 1'b0;
    wait_resp_a("rst fresh ld08", 1'b0, 1'b1, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
